reg_arith_exec_ctrl: RTL and testbench



---
 rtl/reg_arith_exec_ctrl_pkg.sv | 29 ++
 rtl/decode_reg_arith.sv | 39 +++
 rtl/reg_arith_alu.sv | 38 +++
 rtl/reg_arith_exec_ctrl.sv | 137 +++++++++++++
 tb/tb_reg_arith_exec_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arith_exec_ctrl_pkg.sv
// Shared types for the RV32I register-register sequencer: FSM states, ALU op kinds,
// the latched instruction fields and the OP opcode constant.
package instr_type;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {IDLE, DEC, RD1, RD2, EXEC, WB} reg_arith_state_t;

  typedef enum logic [3:0] {
    rak_add, rak_sub, rak_sll, rak_slt, rak_sltu,
    rak_xor, rak_srl, rak_sra, rak_or, rak_and, rak_invalid
  } reg_arith_kind_t;

  // rs1 is consumed straight off the issue bus, so it is not kept.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } ra_instr_t;

  function automatic logic is_shift(input reg_arith_kind_t k);
    return (k == rak_sll) || (k == rak_srl) || (k == rak_sra);
  endfunction

endpackage

// File: rtl/decode_reg_arith.sv
// Registered funct3/funct7 decoder for OP-class instructions; kind is valid one
// cycle after the fields are presented.
module decode_reg_arith
  import instr_type::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output reg_arith_kind_t kind
);

  reg_arith_kind_t kind_d;

  always_comb begin
    kind_d = rak_invalid;
    if (funct7 == F7_BASE) begin
      case (funct3)
        3'b000: kind_d = rak_add;
        3'b001: kind_d = rak_sll;
        3'b010: kind_d = rak_slt;
        3'b011: kind_d = rak_sltu;
        3'b100: kind_d = rak_xor;
        3'b101: kind_d = rak_srl;
        3'b110: kind_d = rak_or;
        default: kind_d = rak_and;
      endcase
    end else if (funct7 == F7_ALT) begin
      if (funct3 == 3'b000)      kind_d = rak_sub;
      else if (funct3 == 3'b101) kind_d = rak_sra;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) kind <= rak_invalid;
    else      kind <= kind_d;
  end

endmodule

// File: rtl/reg_arith_alu.sv
// Combinational ALU for register-register ops. With REG_ARITH_SERIAL_SHIFT_EN
// defined the barrel shifter is dropped and shifts are iterated by the controller.
module reg_arith_alu
  import instr_type::*;
#(
  parameter int XLEN = 32
) (
  input  reg_arith_kind_t  kind,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

`ifndef REG_ARITH_SERIAL_SHIFT_EN
  logic [4:0] shamt;
  assign shamt = b[4:0];
`endif

  always_comb begin
    result = '0;
    case (kind)
      rak_add:  result = a + b;
      rak_sub:  result = a - b;
      rak_slt:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      rak_sltu: result = {{(XLEN-1){1'b0}}, (a < b)};
      rak_xor:  result = a ^ b;
      rak_or:   result = a | b;
      rak_and:  result = a & b;
`ifndef REG_ARITH_SERIAL_SHIFT_EN
      rak_sll:  result = a << shamt;
      rak_srl:  result = a >> shamt;
      rak_sra:  result = XLEN'($signed(a) >>> shamt);
`endif
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/reg_arith_exec_ctrl.sv
// Multi-cycle sequencer for RV32I OP instructions: accept, decode, read rs1/rs2
// over one registered-read port, execute, write rd. Option: REG_ARITH_SERIAL_SHIFT_EN.
module reg_arith_exec_ctrl
  import instr_type::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            err_illegal
);

  reg_arith_state_t state;
  ra_instr_t        instr;
  reg_arith_kind_t  kind;
  logic [XLEN-1:0]  op_a, op_b, alu_res, result_d;
  logic             illegal, exec_done;

  decode_reg_arith u_dec (
    .clk    (clk),
    .rst    (rst),
    .funct3 (instr.funct3),
    .funct7 (instr.funct7),
    .kind   (kind)
  );

  reg_arith_alu #(.XLEN(XLEN)) u_alu (
    .kind   (kind),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  assign illegal     = (instr.opcode != OPCODE_OP) || (kind == rak_invalid);
  assign in_ready    = rst && (state == IDLE);
  assign busy        = (state != IDLE);
  assign err_illegal = (state == RD1) && illegal;

`ifdef REG_ARITH_SERIAL_SHIFT_EN
  logic [XLEN-1:0] sh_acc;
  logic [4:0]      sh_cnt;

  function automatic logic [XLEN-1:0] shift1(input reg_arith_kind_t k, input logic [XLEN-1:0] v);
    case (k)
      rak_sll: return {v[XLEN-2:0], 1'b0};
      rak_sra: return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  // The last shift step folds into the cycle that leaves EXEC, so EXEC spans max(1,shamt).
  always_comb begin
    exec_done = 1'b1;
    result_d  = alu_res;
    if (is_shift(kind)) begin
      exec_done = (sh_cnt <= 5'd1);
      result_d  = (sh_cnt == 5'd1) ? shift1(kind, sh_acc) : sh_acc;
    end
  end
`else
  assign exec_done = 1'b1;
  assign result_d  = alu_res;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      instr    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rf_raddr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
`ifdef REG_ARITH_SERIAL_SHIFT_EN
      sh_acc   <= '0;
      sh_cnt   <= '0;
`endif
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          instr    <= '{funct7: in_instr[31:25], rs2: in_instr[24:20], funct3: in_instr[14:12],
                        rd: in_instr[11:7], opcode: in_instr[6:0]};
          rf_raddr <= in_instr[19:15];
          state    <= DEC;
        end
        DEC: begin
          // rs2 address goes out now so its data lands in RD2.
          rf_raddr <= instr.rs2;
          state    <= RD1;
        end
        RD1: begin
          if (illegal) state <= IDLE;
          else begin
            op_a  <= rf_rdata;
            state <= RD2;
          end
        end
        RD2: begin
          op_b  <= rf_rdata;
`ifdef REG_ARITH_SERIAL_SHIFT_EN
          sh_acc <= op_a;
          sh_cnt <= rf_rdata[4:0];
`endif
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            rf_wdata <= result_d;
            rf_waddr <= instr.rd;
            rf_we    <= (instr.rd != 5'd0);
            state    <= WB;
          end
`ifdef REG_ARITH_SERIAL_SHIFT_EN
          else begin
            sh_acc <= shift1(kind, sh_acc);
            sh_cnt <= sh_cnt - 5'd1;
          end
`endif
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arith_exec_ctrl.sv
// Scoreboard bench for reg_arith_exec_ctrl: directed cases then random OP/illegal
// instructions against a behavioural register-file/ISA model.
module tb_reg_arith_exec_ctrl;

`ifdef REG_ARITH_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        err_illegal;

  reg_arith_exec_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model register file; the DUT's writes are checked but never fed back.
  logic [31:0] regs [32];
  always @(posedge clk) rf_rdata <= regs[rf_raddr];

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input bit alt, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'((sa >>> sh)) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    int t, n, lat, rdy;
    logic [31:0] a, b, val;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    bit legal, busy_bad;
    exp_t e;
    f3 = ins[14:12];
    f7 = ins[31:25];
    rd = ins[11:7];
    val = '0;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      nvec++; nerr++;
      $display("FAIL ready_timeout: in_ready stayed low, expected high (cyc %0d)", cyc);
      return;
    end
    a = regs[ins[19:15]];
    b = regs[ins[24:20]];
    legal = (ins[6:0] == 7'b0110011) &&
            (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    n = cyc;
    in_valid = 1'b1;
    in_instr = ins;
    if (!legal) begin
      e = '{1'b1, n + 2, 5'd0, 32'd0};
      q.push_back(e);
      rdy = 3;
    end else begin
      val = ref_op(f3, f7[5], a, b);
      lat = 5;
      if (SERIAL && (f3 == 3'd1 || f3 == 3'd5))
        lat = 4 + (((b % 32) == 0) ? 1 : int'(b % 32));
      if (rd != 5'd0) begin
        e = '{1'b0, n + lat, rd, val};
        q.push_back(e);
      end
      rdy = lat + 1;
    end
    busy_bad = 1'b0;
    t = 0;
    // While busy, toggle junk onto the issue bus; it must be ignored.
    do begin
      @(negedge clk);
      t++;
      if (!in_ready) begin
        if (!busy) busy_bad = 1'b1;
        in_valid = 1'($urandom % 2);
        in_instr = $urandom;
      end
    end while (!in_ready && t < 100);
    in_valid = 1'b0;
    chk("ready_return_cycle", 32'(cyc), 32'(n + rdy));
    chk("busy_while_in_flight", {31'd0, busy_bad}, 32'd0);
    if (legal && rd != 5'd0) regs[rd] = val;
  endtask

  initial begin
    exp_t e;
    int n;
    logic [6:0] op, f7;
    int r;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst && (rf_we || err_illegal)) begin
          nvec++;
          if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_event: we=%0b err=%0b addr=%0d data=%h, expected no event (cyc %0d)",
                     rf_we, err_illegal, rf_waddr, rf_wdata, cyc);
          end else begin
            e = q.pop_front();
            if (err_illegal !== e.is_err || rf_we !== !e.is_err || cyc != e.cyc ||
                (!e.is_err && (rf_waddr !== e.addr || rf_wdata !== e.data))) begin
              nerr++;
              $display("FAIL %s: cyc=%0d err=%0b addr=%0d data=%h, expected cyc=%0d err=%0b addr=%0d data=%h",
                       e.is_err ? "err_pulse" : "writeback", cyc, err_illegal, rf_waddr, rf_wdata,
                       e.cyc, e.is_err, e.addr, e.data);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_err", {31'd0, err_illegal}, 32'd0);
    chk("reset_raddr", {27'd0, rf_raddr}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));   // add
    issue(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33));   // sub
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd3, 5'd7, 7'h33));   // sltu
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd2, 5'd8, 7'h33));   // slt
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd3, 5'd9, 7'h33));   // sltu
    regs[1] = 32'h8000_0000; regs[2] = 32'd4;
    issue(rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd5, 7'h33));   // sra
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd5, 5'd6, 7'h33));   // srl
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd1, 5'd10, 7'h33));  // sll
    issue(rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd11, 7'h33));  // rs1==rs2
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33));   // rd=x0
    issue(rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd12, 7'h33));  // mul encoding
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, 7'h13));  // op-imm opcode

    // Abort in EXEC: no write may follow.
    regs[1] = 32'd5; regs[2] = 32'd7;
    in_valid = 1'b1;
    in_instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd13, 7'h33);
    n = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < n + 4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_rf_we", {31'd0, rf_we}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_rf_we_held", {31'd0, rf_we}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));

    for (int i = 1; i < 32; i++) begin
      r = int'($urandom % 6);
      regs[i] = (r == 0) ? 32'h8000_0000 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? ($urandom % 40) : $urandom;
    end
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom % 10);
      op = (r == 0) ? 7'h13 : (r == 1) ? 7'($urandom) : 7'h33;
      r = int'($urandom % 8);
      f7 = (r < 5) ? 7'h00 : (r < 7) ? 7'h20 : 7'h01;
      issue(rtype(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
